// File: rtl/aurora_frame_pkg.sv
// Shared types and constants for the Aurora TX framing block.
package aurora_frame_pkg;

    localparam int          CNT_W        = 11;
    localparam logic [15:0] HEADER_MAGIC = 16'h55AA;
    localparam logic [3:0]  KEEP_ALL     = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_HEAD  = 3'd2,
        ST_DATA  = 3'd3,
        ST_FLUSH = 3'd4
    } frame_state_e;

endpackage

// File: rtl/aurora_frame_sync2.sv
// Two-flop level synchronizer for the ADC acquisition window strobes.
module aurora_frame_sync2 (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aurora_frame_gen.sv
// Drains the laser/particle TX FIFO into AXI4-Stream frames for the Aurora core.
// Optional FRAME_HEADER_EN: prefixes each frame with {16'h55AA, seq}.
//
// state  | meaning
// IDLE   | waiting for link up and an acquisition start edge
// ARMED  | acquisition open, deciding full/short frame or end of acquisition
// HEAD   | presenting the header word (FRAME_HEADER_EN builds only)
// DATA   | streaming FIFO words, one pop per handshake
// FLUSH  | link lost, popping the rest of the current frame to keep FIFO alignment
module aurora_frame_gen
    import aurora_frame_pkg::*;
#(
    parameter int  FRAME_LEN = 64,
    parameter real TCQ       = 0.1
) (
    input  logic             USER_CLK,
    input  logic             RESET_N,
    input  logic             CHANNEL_UP,
    input  logic             adc_start,
    input  logic             adc_end,
    input  logic [CNT_W-1:0] aurora_rd_data_count,
    input  logic [31:0]      aurora_txdata,
    output logic             aurora_txen,
    output logic             tx_tvalid,
    output logic [31:0]      tx_data,
    output logic [3:0]       tx_tkeep,
    output logic             tx_tlast,
    input  logic             tx_tready
);

    localparam logic [CNT_W-1:0] FLEN = CNT_W'(FRAME_LEN);

`ifdef FRAME_HEADER_EN
    localparam frame_state_e ST_FIRST = ST_HEAD;
`else
    localparam frame_state_e ST_FIRST = ST_DATA;
`endif

    frame_state_e     state, state_nxt;
    logic             start_s, end_s, start_q;
    logic [CNT_W-1:0] len, wcnt, rem;
    logic [15:0]      seq;
    logic             hs, last_word, start_rise, full_avail;

    aurora_frame_sync2 u_sync_start (
        .clk_i (USER_CLK),
        .rst_n (RESET_N),
        .d     (adc_start),
        .q     (start_s)
    );

    aurora_frame_sync2 u_sync_end (
        .clk_i (USER_CLK),
        .rst_n (RESET_N),
        .d     (adc_end),
        .q     (end_s)
    );

    assign hs         = tx_tvalid & tx_tready;
    assign last_word  = (wcnt == (len - CNT_W'(1)));
    assign start_rise = start_s & ~start_q;
    assign full_avail = (aurora_rd_data_count >= FLEN);
    assign tx_tkeep   = KEEP_ALL;

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (CHANNEL_UP && start_rise) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                // A full frame always wins over an end-of-acquisition short frame
                if (!CHANNEL_UP)                      state_nxt = ST_FLUSH;
                else if (full_avail)                  state_nxt = ST_FIRST;
                else if (end_s)
                    state_nxt = (aurora_rd_data_count != '0) ? ST_FIRST : ST_IDLE;
            end
            ST_HEAD: begin
                if (!CHANNEL_UP) state_nxt = ST_FLUSH;
                else if (hs)     state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (!CHANNEL_UP)          state_nxt = ST_FLUSH;
                else if (hs && last_word) state_nxt = ST_ARMED;
            end
            ST_FLUSH: begin
                if (rem <= CNT_W'(1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        aurora_txen = 1'b0;
        tx_tvalid   = 1'b0;
        tx_data     = '0;
        tx_tlast    = 1'b0;
        case (state)
            ST_HEAD: begin
                tx_tvalid = 1'b1;
                tx_data   = {HEADER_MAGIC, seq};
            end
            ST_DATA: begin
                tx_tvalid   = 1'b1;
                tx_data     = aurora_txdata;
                tx_tlast    = last_word;
                aurora_txen = tx_tready;
            end
            ST_FLUSH: begin
                aurora_txen = (rem != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            start_q <= 1'b0;
            len     <= CNT_W'(1);
            wcnt    <= '0;
            rem     <= '0;
            seq     <= '0;
        end else begin
            start_q <= start_s;
            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_ARMED) seq <= '0;
                end
                ST_ARMED: begin
                    // Only consumed when leaving for a frame, where count is nonzero
                    len  <= full_avail ? FLEN : aurora_rd_data_count;
                    wcnt <= '0;
                    rem  <= '0;
                end
                ST_HEAD: begin
                    if (state_nxt == ST_FLUSH) rem <= len;
                end
                ST_DATA: begin
                    if (hs) begin
                        wcnt <= wcnt + CNT_W'(1);
                        if (last_word) seq <= seq + 16'd1;
                    end
                    if (state_nxt == ST_FLUSH) rem <= len - wcnt - CNT_W'(hs);
                end
                ST_FLUSH: begin
                    if (rem != '0) rem <= rem - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aurora_frame_gen.sv
// Self-checking bench for aurora_frame_gen: table-driven frame scenarios plus
// hand-written link-drop and asynchronous-reset sequences.
module tb_aurora_frame_gen;

`ifdef FRAME_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int FL = 4;

    logic        USER_CLK   = 1'b0;
    logic        RESET_N    = 1'b1;
    logic        CHANNEL_UP = 1'b0;
    logic        adc_start  = 1'b0;
    logic        adc_end    = 1'b0;
    logic        tx_tready  = 1'b1;
    logic [10:0] aurora_rd_data_count;
    logic [31:0] aurora_txdata;
    logic        aurora_txen;
    logic        tx_tvalid;
    logic [31:0] tx_data;
    logic [3:0]  tx_tkeep;
    logic        tx_tlast;

    aurora_frame_gen #(.FRAME_LEN(FL)) dut (
        .USER_CLK             (USER_CLK),
        .RESET_N              (RESET_N),
        .CHANNEL_UP           (CHANNEL_UP),
        .adc_start            (adc_start),
        .adc_end              (adc_end),
        .aurora_rd_data_count (aurora_rd_data_count),
        .aurora_txdata        (aurora_txdata),
        .aurora_txen          (aurora_txen),
        .tx_tvalid            (tx_tvalid),
        .tx_data              (tx_data),
        .tx_tkeep             (tx_tkeep),
        .tx_tlast             (tx_tlast),
        .tx_tready            (tx_tready)
    );

    always #5 USER_CLK = ~USER_CLK;

    // FIFO model: word k holds D000_0000 + k; rp counts pops, wp counts pushes
    int rp = 0;
    int wp = 0;
    assign aurora_rd_data_count = 11'(wp - rp);
    assign aurora_txdata        = 32'hD000_0000 + 32'(rp);

    always @(posedge USER_CLK) if (aurora_txen) rp <= rp + 1;

    int          tests = 0;
    int          fails = 0;
    int          tlast_cnt = 0;
    bit          tog = 1'b0;
    bit          flush_ok = 1'b0;
    logic [32:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    typedef struct {
        int words;
        bit toggle;
        int frames;
        int last_len;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge USER_CLK) begin
        logic [32:0] e;
        if (!RESET_N) begin
            prev_stall <= 1'b0;
        end else begin
            if (!flush_ok) begin
                chk("txen_vs_handshake", aurora_txen, tx_tvalid & tx_tready);
                if (prev_stall) begin
                    chk("stall_valid", tx_tvalid, 1);
                    chk("stall_data", tx_data, prev_data);
                    chk("stall_last", tx_tlast, prev_last);
                end
            end
            if (tx_tvalid && tx_tready) begin
                if (tx_tlast) tlast_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none", {tx_tlast, tx_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {tx_tlast, tx_data}, e);
                end
            end
            prev_stall <= tx_tvalid && !tx_tready;
            prev_data  <= tx_data;
            prev_last  <= tx_tlast;
        end
    end

    task automatic step();
        @(posedge USER_CLK);
        #1;
        if (tog) tx_tready = ~tx_tready;
    endtask

    task automatic build_exp(input int base, input int frames, input int last_len);
        int k = base;
        for (int f = 0; f < frames; f++) begin
            int n = (f == frames - 1) ? last_len : FL;
            if (HDR) exp_q.push_back({1'b0, 16'h55AA, 16'(f)});
            for (int j = 0; j < n; j++) begin
                exp_q.push_back({(j == n - 1), 32'hD000_0000 + 32'(k)});
                k++;
            end
        end
    endtask

    task automatic pulse_start();
        adc_start = 1'b1;
        repeat (3) step();
        adc_start = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int base = wp;
        int t0   = tlast_cnt;
        int c    = 0;
        build_exp(base, v.frames, v.last_len);
        wp        = wp + v.words;
        tx_tready = 1'b1;
        tog       = v.toggle;
        adc_end   = 1'b1;
        pulse_start();
        while (c < 400 && !(exp_q.size() == 0 && rp == wp)) begin
            step();
            c++;
        end
        repeat (8) step();
        chk({tag, "_pops"}, rp - base, v.words);
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_frames"}, tlast_cnt - t0, v.frames);
        chk({tag, "_idle_valid"}, tx_tvalid, 0);
        exp_q.delete();
        adc_end   = 1'b0;
        tog       = 1'b0;
        tx_tready = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c;
        vecs[0] = '{words: 8, toggle: 1'b0, frames: 2, last_len: 4};
        vecs[1] = '{words: 3, toggle: 1'b0, frames: 1, last_len: 3};
        vecs[2] = '{words: 8, toggle: 1'b1, frames: 2, last_len: 4};
        vecs[3] = '{words: 5, toggle: 1'b0, frames: 2, last_len: 1};
        vecs[4] = '{words: 0, toggle: 1'b0, frames: 0, last_len: 0};
        vecs[5] = '{words: 4, toggle: 1'b1, frames: 1, last_len: 4};
        vecs[6] = '{words: 4, toggle: 1'b0, frames: 1, last_len: 4};
        vecs[7] = '{words: 6, toggle: 1'b1, frames: 2, last_len: 2};

        #2 RESET_N = 1'b0;
        #1;
        chk("rst_tvalid", tx_tvalid, 0);
        chk("rst_txen", aurora_txen, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_tlast", tx_tlast, 0);
        chk("rst_tkeep", tx_tkeep, 4'hF);
        repeat (3) step();
        RESET_N    = 1'b1;
        CHANNEL_UP = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 6; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

        // Link drop after two data words of a four-word frame
        base = wp;
        build_exp(base, 1, 4);
        wp = wp + 4;
        tx_tready = 1'b1;
        pulse_start();
        c = 0;
        while (c < 100 && (rp - base) < 2) begin
            step();
            c++;
        end
        chk("drop_at_two", rp - base, 2);
        CHANNEL_UP = 1'b0;
        tx_tready  = 1'b0;
        flush_ok   = 1'b1;
        step();
        chk("drop_tvalid", tx_tvalid, 0);
        repeat (8) step();
        chk("drop_pops", rp - base, 4);
        chk("drop_aligned", wp - rp, 0);
        chk("drop_idle_valid", tx_tvalid, 0);
        exp_q.delete();
        CHANNEL_UP = 1'b1;
        tx_tready  = 1'b1;
        repeat (3) step();
        flush_ok = 1'b0;
        run_vector(vecs[6], "after_drop");

        // Asynchronous reset in the middle of a frame
        base = wp;
        build_exp(base, 2, 4);
        wp = wp + 8;
        adc_end = 1'b1;
        pulse_start();
        c = 0;
        while (c < 100 && (rp - base) < 2) begin
            step();
            c++;
        end
        chk("rst_mid_reached", rp - base, 2);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_mid_tvalid", tx_tvalid, 0);
        chk("rst_mid_txen", aurora_txen, 0);
        chk("rst_mid_data", tx_data, 0);
        chk("rst_mid_tlast", tx_tlast, 0);
        chk("rst_mid_tkeep", tx_tkeep, 4'hF);
        exp_q.delete();
        adc_end = 1'b0;
        wp      = rp;
        repeat (3) step();
        RESET_N = 1'b1;
        repeat (4) step();
        chk("rst_mid_after_valid", tx_tvalid, 0);
        run_vector(vecs[7], "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
